// File: rtl/axi_rd_pkg.sv
// Shared constants for the SDRAM-to-AXI read data path:
// response codes, reader FSM encoding, output buffer depth.
package axi_rd_pkg;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BURST = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam int RBUF_DEPTH = 3;

  // Ring pointer advance for the RBUF_DEPTH-entry buffer.
  function automatic logic [1:0] rbuf_next(input logic [1:0] p);
    return (p == 2'(RBUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/r_skid_buf.sv
// 3-entry synchronous FIFO holding {rlast, rdata} beats for the R channel.
// Ports: clk, reset_n, push/push_data, pop, head (oldest entry), occ (0..3).
module r_skid_buf
  import axi_rd_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   occ
);

  logic [W-1:0] mem [RBUF_DEPTH];
  logic [1:0]   wp;
  logic [1:0]   rp;

  assign head = mem[rp];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
      for (int i = 0; i < RBUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wp] <= push_data;
        wp      <= rbuf_next(wp);
      end
      if (pop) begin
        rp <= rbuf_next(rp);
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/axi_rdata_fifo_reader.sv
// Pops len+1 beats from the async data FIFO and serves them on an AXI4 R channel.
// Ports: cmd_* burst command, fifo_* FIFO read port, r* AXI R channel, busy.
module axi_rdata_fifo_reader
  import axi_rd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 8
) (
  input  logic              rd_clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [ID_W-1:0]   cmd_id,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_data_out,
  input  logic              fifo_empty,
  output logic              rvalid,
  input  logic              rready,
  output logic [DATA_W-1:0] rdata,
  output logic [ID_W-1:0]   rid,
  output logic              rlast,
  output logic [1:0]        rresp,
  output logic              busy
);

  localparam int CW = LEN_W + 1;

  logic [1:0]       state;
  logic [LEN_W-1:0] len_q;
  logic [ID_W-1:0]  id_q;
  logic [CW-1:0]    issue_cnt;
  logic [CW-1:0]    issue_nxt;
  logic [CW-1:0]    beat_cnt;
  logic [CW-1:0]    last_idx;
  logic [CW-1:0]    beats;
  logic             inflight;
  logic [1:0]       occ;
  logic [DATA_W:0]  head;
  logic [DATA_W:0]  push_word;
  logic             push_last;
  logic             hs;
  logic             last_hs;

  assign last_idx  = {1'b0, len_q};
  assign beats     = last_idx + CW'(1);
  assign issue_nxt = issue_cnt + CW'(fifo_rd_en);

  // Only registered terms gate the pop, so rready never reaches fifo_rd_en.
  assign fifo_rd_en = (state == BURST) && !fifo_empty
                   && (issue_cnt <= last_idx)
                   && (({1'b0, occ} + {2'b0, inflight}) < 3'd3);

  // The beat arriving now was popped last cycle: its index is issue_cnt-1.
  assign push_last = (issue_cnt == beats);
  assign push_word = {push_last, fifo_data_out};

  r_skid_buf #(
    .W (DATA_W + 1)
  ) u_buf (
    .clk       (rd_clk),
    .reset_n   (reset_n),
    .push      (inflight),
    .push_data (push_word),
    .pop       (hs),
    .head      (head),
    .occ       (occ)
  );

  assign rvalid    = (occ != 2'd0);
  assign hs        = rvalid && rready;
  assign rdata     = head[DATA_W-1:0];
  assign rlast     = rvalid && head[DATA_W];
  assign last_hs   = hs && (beat_cnt == last_idx);
  assign rid       = id_q;
  assign rresp     = RESP_OKAY;
  assign busy      = (state != IDLE);
  assign cmd_ready = reset_n && (state == IDLE);

  always_ff @(posedge rd_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      len_q     <= '0;
      id_q      <= '0;
      issue_cnt <= '0;
      beat_cnt  <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      if (hs) begin
        beat_cnt <= beat_cnt + CW'(1);
      end
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            len_q     <= cmd_len;
            id_q      <= cmd_id;
            issue_cnt <= '0;
            beat_cnt  <= '0;
            state     <= BURST;
          end
        end
        BURST: begin
          issue_cnt <= issue_nxt;
          if (issue_nxt == beats) begin
            state <= last_hs ? IDLE : DRAIN;
          end
        end
        DRAIN: begin
          if (last_hs) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rdata_fifo_reader.sv
// Randomized bench for axi_rdata_fifo_reader with a queue-based FIFO
// and an expected-beat reference model.
module tb_axi_rdata_fifo_reader;

  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int LEN_W  = 8;

  logic              rd_clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [ID_W-1:0]   cmd_id = '0;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_data_out = '0;
  logic              fifo_empty = 1'b1;
  logic              rvalid;
  logic              rready = 1'b0;
  logic [DATA_W-1:0] rdata;
  logic [ID_W-1:0]   rid;
  logic              rlast;
  logic [1:0]        rresp;
  logic              busy;

  always #5 rd_clk = ~rd_clk;

  axi_rdata_fifo_reader #(
    .DATA_W (DATA_W),
    .ID_W   (ID_W),
    .LEN_W  (LEN_W)
  ) dut (
    .rd_clk        (rd_clk),
    .reset_n       (reset_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_len       (cmd_len),
    .cmd_id        (cmd_id),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_data_out (fifo_data_out),
    .fifo_empty    (fifo_empty),
    .rvalid        (rvalid),
    .rready        (rready),
    .rdata         (rdata),
    .rid           (rid),
    .rlast         (rlast),
    .rresp         (rresp),
    .busy          (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] fifo_q [$];

  bit                h_rden [$];
  bit                h_rvalid [$];
  bit                h_rready [$];
  bit                h_cmdrdy [$];
  bit                h_busy [$];
  logic [DATA_W-1:0] h_rdata [$];
  bit                h_rlast [$];

  logic [DATA_W-1:0] rx_data [$];
  bit                rx_last [$];
  logic [ID_W-1:0]   rx_id [$];
  int                rx_cyc [$];

  task automatic clear_hist();
    h_rden.delete(); h_rvalid.delete(); h_rready.delete();
    h_cmdrdy.delete(); h_busy.delete(); h_rdata.delete(); h_rlast.delete();
    rx_data.delete(); rx_last.delete(); rx_id.delete(); rx_cyc.delete();
  endtask

  // One clock cycle: observe at negedge+1, then model the FIFO read port.
  task automatic tick();
    bit pop;
    #1;
    if (rvalid && rready) begin
      rx_data.push_back(rdata);
      rx_last.push_back(rlast);
      rx_id.push_back(rid);
      rx_cyc.push_back(h_rden.size());
    end
    h_rden.push_back(fifo_rd_en);
    h_rvalid.push_back(rvalid);
    h_rready.push_back(rready);
    h_cmdrdy.push_back(cmd_ready);
    h_busy.push_back(busy);
    h_rdata.push_back(rdata);
    h_rlast.push_back(rlast);
    pop = fifo_rd_en;
    @(posedge rd_clk);
    #1;
    if (pop && fifo_q.size() > 0) fifo_data_out = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
    @(negedge rd_clk);
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic send_cmd(input logic [LEN_W-1:0] len, input logic [ID_W-1:0] id);
    cmd_valid = 1'b1;
    cmd_len   = len;
    cmd_id    = id;
    tick();
    cmd_valid = 1'b0;
    cmd_len   = LEN_W'($urandom);
    cmd_id    = ID_W'($urandom);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rready  = 1'b0;
    repeat (2) @(negedge rd_clk);
    #1;
    n_checks++;
    if ({cmd_ready, fifo_rd_en, rvalid, rdata, rid, rlast, rresp, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b rd_en=%b rvalid=%b rdata=%h rid=%h rlast=%b rresp=%b busy=%b want all 0",
               cmd_ready, fifo_rd_en, rvalid, rdata, rid, rlast, rresp, busy);
    end
    reset_n = 1'b1;
    #1;
    n_checks++;
    if ({cmd_ready, busy, rvalid, fifo_rd_en} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_release: rdy/busy/rvalid/rd_en=%b want 1000",
               {cmd_ready, busy, rvalid, fifo_rd_en});
    end
    @(negedge rd_clk);
  endtask

  task automatic test_single();
    int n;
    clear_hist();
    rready = 1'b1;
    push_word(32'hA5A5_A5A5);
    send_cmd(8'd0, 4'd3);
    repeat (7) tick();
    n = 0;
    foreach (h_rden[i]) n += int'(h_rden[i]);
    n_checks++;
    if (n != 1 || h_rden[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_pop: pulses=%0d rd_en@1=%b want 1 pulse at cycle 1", n, h_rden[1]);
    end
    n_checks++;
    if (rx_data.size() != 1 || h_rvalid[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_count: beats=%0d rvalid@2=%b want 1 beat, rvalid@2=0",
               rx_data.size(), h_rvalid[2]);
    end
    n_checks++;
    if (rx_cyc[0] != 3 || rx_data[0] !== 32'hA5A5_A5A5 || rx_id[0] !== 4'd3 || rx_last[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_beat: cyc=%0d data=%h id=%h last=%b want cyc 3 data a5a5a5a5 id 3 last 1",
               rx_cyc[0], rx_data[0], rx_id[0], rx_last[0]);
    end
    n_checks++;
    if (h_busy[3] !== 1'b1 || h_busy[4] !== 1'b0 || h_cmdrdy[4] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_busy: busy@3=%b busy@4=%b rdy@4=%b want 1 0 1",
               h_busy[3], h_busy[4], h_cmdrdy[4]);
    end
  endtask

  task automatic test_burst4();
    logic [ID_W-1:0] id;
    int n;
    clear_hist();
    rready = 1'b1;
    id = ID_W'($urandom);
    for (int i = 1; i <= 4; i++) push_word(DATA_W'(i));
    send_cmd(8'd3, id);
    repeat (10) tick();
    n_checks++;
    if (rx_data.size() != 4) begin
      n_fail++;
      $display("FAIL burst4_count: beats=%0d want 4", rx_data.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rx_data[i] !== DATA_W'(i + 1) || rx_last[i] !== (i == 3) ||
          rx_id[i] !== id || rx_cyc[i] != 3 + i) begin
        n_fail++;
        $display("FAIL burst4_beat%0d: data=%h last=%b id=%h cyc=%0d want %h %b %h %0d",
                 i, rx_data[i], rx_last[i], rx_id[i], rx_cyc[i], i + 1, i == 3, id, 3 + i);
      end
    end
    n = 0;
    foreach (h_rden[i]) n += int'(h_rden[i]);
    n_checks++;
    if (n != 4 || {h_rden[1], h_rden[2], h_rden[3], h_rden[4]} !== 4'hf) begin
      n_fail++;
      $display("FAIL burst4_rden: pulses=%0d want 4 consecutive from cycle 1", n);
    end
  endtask

  task automatic test_backpressure();
    logic [ID_W-1:0] id;
    int n_early;
    int n_stall;
    int bad;
    clear_hist();
    rready = 1'b0;
    id = ID_W'($urandom);
    for (int i = 1; i <= 4; i++) push_word(DATA_W'(i));
    send_cmd(8'd3, id);
    for (int c = 1; c < 20; c++) begin
      rready = (c >= 8);
      tick();
    end
    n_early = 0;
    n_stall = 0;
    for (int c = 0; c <= 7; c++) n_early += int'(h_rden[c]);
    for (int c = 4; c <= 7; c++) n_stall += int'(h_rden[c]);
    n_checks++;
    if (n_early != 3 || n_stall != 0) begin
      n_fail++;
      $display("FAIL bp_rden: pops by cycle 7=%0d in 4..7=%0d want 3 and 0", n_early, n_stall);
    end
    bad = 0;
    for (int c = 3; c <= 7; c++) begin
      if (h_rvalid[c] !== 1'b1 || h_rdata[c] !== 32'h1) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold: %0d stalled cycles lost rvalid or rdata, want rdata 1 held", bad);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (rx_data[i] !== DATA_W'(i + 1) || rx_last[i] !== (i == 3)) bad++;
    end
    n_checks++;
    if (rx_data.size() != 4 || bad != 0) begin
      n_fail++;
      $display("FAIL bp_order: beats=%0d bad=%0d want 4 beats 1..4 in order", rx_data.size(), bad);
    end
  endtask

  task automatic test_empty_gap();
    logic [ID_W-1:0] id;
    int n;
    int rdy_bad;
    clear_hist();
    rready = 1'b1;
    id = ID_W'($urandom);
    send_cmd(8'd1, id);
    for (int c = 1; c < 20; c++) begin
      if (c == 5) push_word(32'h10);
      if (c == 9) push_word(32'h20);
      tick();
    end
    n_checks++;
    if (rx_data.size() != 2 || rx_data[0] !== 32'h10 || rx_data[1] !== 32'h20 ||
        rx_last[0] !== 1'b0 || rx_last[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_beats: n=%0d d0=%h l0=%b d1=%h l1=%b want 2 beats 10/0 20/1",
               rx_data.size(), rx_data[0], rx_last[0], rx_data[1], rx_last[1]);
    end
    n_checks++;
    if (rx_cyc[1] - rx_cyc[0] < 2 || h_rvalid[rx_cyc[0] + 1] !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_rvalid: beat cycles %0d,%0d want rvalid low between",
               rx_cyc[0], rx_cyc[1]);
    end
    rdy_bad = 0;
    for (int c = 1; c <= rx_cyc[1]; c++) rdy_bad += int'(h_cmdrdy[c]);
    n_checks++;
    if (rdy_bad != 0 || h_cmdrdy[rx_cyc[1] + 1] !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_cmd_ready: early ready cycles=%0d ready after last=%b want 0 and 1",
               rdy_bad, h_cmdrdy[rx_cyc[1] + 1]);
    end
    n = 0;
    foreach (h_rden[i]) n += int'(h_rden[i]);
    n_checks++;
    if (n != 2) begin
      n_fail++;
      $display("FAIL gap_pops: pops=%0d want 2", n);
    end
  endtask

  task automatic test_long();
    logic [DATA_W-1:0] exp [$];
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] w;
    int bad;
    int nlast;
    clear_hist();
    rready = 1'b1;
    id = ID_W'($urandom);
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      exp.push_back(w);
      push_word(w);
    end
    send_cmd(8'd255, id);
    repeat (270) tick();
    n_checks++;
    if (rx_data.size() != 256) begin
      n_fail++;
      $display("FAIL long_count: beats=%0d want 256", rx_data.size());
    end
    bad = 0;
    nlast = 0;
    foreach (rx_data[i]) begin
      if (i < 256 && (rx_data[i] !== exp[i] || rx_id[i] !== id)) bad++;
      if (rx_last[i]) nlast++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL long_data: %0d beats wrong data or id, want 0", bad);
    end
    n_checks++;
    if (nlast != 1 || rx_last[255] !== 1'b1) begin
      n_fail++;
      $display("FAIL long_rlast: rlast count=%0d on beat 256=%b want 1 and 1", nlast, rx_last[255]);
    end
    n_checks++;
    if (rx_cyc[255] - rx_cyc[0] != 255 || h_busy[269] !== 1'b0) begin
      n_fail++;
      $display("FAIL long_rate: span=%0d busy_end=%b want 255 and 0",
               rx_cyc[255] - rx_cyc[0], h_busy[269]);
    end
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] w;
    logic [ID_W-1:0]   id;
    int n;
    int bad;
    clear_hist();
    rready = 1'b1;
    for (int i = 0; i < 8; i++) push_word($urandom);
    send_cmd(8'd7, ID_W'($urandom));
    repeat (4) tick();
    n_checks++;
    if (rx_data.size() != 2 || rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_setup: beats=%0d rvalid=%b want 2 and 1", rx_data.size(), rvalid);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({cmd_ready, fifo_rd_en, rvalid, rdata, rid, rlast, rresp, busy} !== '0) begin
      n_fail++;
      $display("FAIL rmid_outputs: rdy=%b rd_en=%b rvalid=%b rdata=%h rid=%h rlast=%b busy=%b want all 0",
               cmd_ready, fifo_rd_en, rvalid, rdata, rid, rlast, busy);
    end
    @(negedge rd_clk);
    reset_n = 1'b1;
    clear_hist();
    repeat (5) tick();
    n = 0;
    bad = 0;
    foreach (h_rden[i]) begin
      n += int'(h_rden[i]);
      if (h_cmdrdy[i] !== 1'b1 || h_busy[i] !== 1'b0 || h_rvalid[i] !== 1'b0) bad++;
    end
    n_checks++;
    if (n != 0 || bad != 0) begin
      n_fail++;
      $display("FAIL rmid_idle: pops=%0d non-idle cycles=%0d want 0 and 0", n, bad);
    end
    clear_hist();
    w  = fifo_q[0];
    id = ID_W'($urandom);
    send_cmd(8'd0, id);
    repeat (6) tick();
    n_checks++;
    if (rx_data.size() != 1 || rx_data[0] !== w || rx_id[0] !== id || rx_last[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_new: n=%0d data=%h id=%h last=%b want 1 beat %h %h 1",
               rx_data.size(), rx_data[0], rx_id[0], rx_last[0], w, id);
    end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] exp [$];
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] w;
    int len;
    int npush;
    int cyc;
    int bad;
    int unstable;
    bit done;
    fifo_q.delete();
    fifo_empty = 1'b1;
    for (int b = 0; b < 6; b++) begin
      clear_hist();
      exp.delete();
      len   = $urandom_range(0, 15);
      id    = ID_W'($urandom);
      npush = 0;
      rready = $urandom_range(0, 1);
      send_cmd(LEN_W'(len), id);
      done = 1'b0;
      cyc  = 0;
      while (!done && cyc < 200) begin
        if (npush <= len && $urandom_range(0, 1) == 1) begin
          w = $urandom;
          exp.push_back(w);
          push_word(w);
          npush++;
        end
        rready = ($urandom_range(0, 2) != 0);
        tick();
        cyc++;
        done = (rx_data.size() == len + 1) && !busy;
      end
      n_checks++;
      if (!done) begin
        n_fail++;
        $display("FAIL rand%0d_done: beats=%0d busy=%b want %0d beats and idle within 200 cycles",
                 b, rx_data.size(), busy, len + 1);
      end
      bad = 0;
      foreach (rx_data[i]) begin
        if (i >= exp.size() || rx_data[i] !== exp[i] ||
            rx_last[i] !== (i == len) || rx_id[i] !== id) bad++;
      end
      n_checks++;
      if (bad != 0 || rx_data.size() != len + 1) begin
        n_fail++;
        $display("FAIL rand%0d_beats: n=%0d bad=%0d want %0d beats matching model",
                 b, rx_data.size(), bad, len + 1);
      end
      unstable = 0;
      for (int c = 1; c < h_rvalid.size(); c++) begin
        if (h_rvalid[c-1] && !h_rready[c-1] &&
            (h_rvalid[c] !== 1'b1 || h_rdata[c] !== h_rdata[c-1] || h_rlast[c] !== h_rlast[c-1]))
          unstable++;
      end
      n_checks++;
      if (unstable != 0) begin
        n_fail++;
        $display("FAIL rand%0d_stable: %0d stalled beats changed, want 0", b, unstable);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge rd_clk);
    test_reset();
    test_single();
    test_burst4();
    test_backpressure();
    test_empty_gap();
    test_long();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
